// File: rtl/cmn_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with threshold flags and sticky overflow/underflow status.
// Latency: a word written at edge N is visible on out_data/out_valid right after edge N; no same-cycle bypass.
// Backpressure: in_ready drops when full or in reset; it depends only on the registered count, never on out_ready.
module cmn_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,        // must be a power of two, >= 2
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     ovf_sticky,
    output logic                     udf_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(AEMPTY_TH);

    // Storage is deliberately left out of reset; only the bookkeeping is cleared.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             udf_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // full/empty come from the registered count only, so in_ready has no path from out_ready.
    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);

    assign in_ready  = !full && !rst;
    assign out_valid = !empty && !rst;
    assign out_data  = mem[rd_ptr];

    // flush wins over any handshake in the same cycle; the offered word is dropped.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Status outputs are forced to their idle values for as long as reset is held.
    assign count        = rst ? '0 : cnt_q;
    assign almost_full  = !rst && (cnt_q >= CNT_AFULL);
    assign almost_empty = rst || (cnt_q <= CNT_AEMPT);
    assign ovf_sticky   = !rst && ovf_q;
    assign udf_sticky   = !rst && udf_q;

    // Pointer, occupancy and sticky-flag state; reset and flush clear the same set of registers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (in_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end
            if (out_ready && !out_valid) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Write port: the slot under wr_ptr takes the payload on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_cmn_sync_fifo.sv
// Testbench for cmn_sync_fifo (DATA_W=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1).
// Latency: directed scenarios followed by biased random traffic with flush and reset injection.
// Backpressure: random in_valid/out_ready; a queue model predicts occupancy, flags and data order.
module tb_cmn_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [2:0]    count;
    logic          almost_full;
    logic          almost_empty;
    logic          ovf_sticky;
    logic          udf_sticky;

    cmn_sync_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF_TH),
        .AEMPTY_TH (AE_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_sticky   (ovf_sticky),
        .udf_sticky   (udf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: occupancy as a plain integer, words in a queue.
    int            m_cnt   = 0;
    bit            m_ovf   = 0;
    bit            m_udf   = 0;
    bit            started = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs held stable across it.
    always @(posedge clk) begin
        started = 1;
        if (rst || flush) begin
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            exp_q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (m_cnt < DEPTH);
            do_pop  = out_ready && (m_cnt > 0);
            if (in_valid && m_cnt == DEPTH) m_ovf = 1;
            if (out_ready && m_cnt == 0)    m_udf = 1;
            if (do_push) exp_q.push_back(in_data);
            m_cnt = m_cnt + int'(do_push) - int'(do_pop);
        end
    end

    // Monitor: compares status against the model and pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",     int'(in_ready),     int'(!rst && m_cnt < DEPTH));
            chk("out_valid",    int'(out_valid),    int'(!rst && m_cnt > 0));
            chk("count",        int'(count),        rst ? 0 : m_cnt);
            chk("almost_full",  int'(almost_full),  int'(!rst && m_cnt >= AF_TH));
            chk("almost_empty", int'(almost_empty), int'(rst || m_cnt <= AE_TH));
            chk("ovf_sticky",   int'(ovf_sticky),   int'(!rst && m_ovf));
            chk("udf_sticky",   int'(udf_sticky),   int'(!rst && m_udf));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_data_unexpected", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] drain_tbl [4];

    initial begin
        drain_tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_aempty", int'(almost_empty), 1);

        // Fill to full, then one push too many.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = drain_tbl[i];
            step();
            @(negedge clk);
            chk("fill_count", int'(count), i + 1);
            chk("fill_afull", int'(almost_full), int'(i + 1 >= 3));
        end
        chk("full_in_ready", int'(in_ready), 0);
        in_data = 8'h55;
        step();
        @(negedge clk);
        chk("ovf_set", int'(ovf_sticky), 1);
        chk("ovf_count", int'(count), 4);

        // Drain in order, then one read too many.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", int'(out_data), int'(drain_tbl[i]));
            step();
            @(negedge clk);
        end
        chk("drain_empty", int'(out_valid), 0);
        step();
        @(negedge clk);
        chk("udf_set", int'(udf_sticky), 1);

        // Continuous streaming across several pointer wraps.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'(i);
            step();
            @(negedge clk);
            chk("stream_cnt_le1", int'(count <= 1), 1);
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Full with simultaneous push and pop: pop only.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'($urandom);
            step();
        end
        @(negedge clk);
        chk("full2_count", int'(count), 4);
        out_ready = 1'b1;
        in_data   = 8'h77;
        step();
        @(negedge clk);
        chk("fullpop_count", int'(count), 3);
        chk("fullpop_in_ready", int'(in_ready), 1);

        // Flush with a concurrent push at count 2.
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("preflush_count", int'(count), 2);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", int'(count), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_ovf", int'(ovf_sticky), 0);
        chk("flush_udf", int'(udf_sticky), 0);

        // Mid-operation reset at count 3.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("inrst_in_ready", int'(in_ready), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_count", int'(count), 0);
        chk("postrst_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", int'(out_valid), 1);
        chk("postrst_out_data", int'(out_data), 8'hA5);

        // Random traffic; bias alternates between filling, draining and balanced.
        for (int c = 0; c < 3000; c++) begin
            int p_in;
            int p_out;
            case ((c / 100) % 3)
                0:       begin p_in = 80; p_out = 30; end
                1:       begin p_in = 30; p_out = 80; end
                default: begin p_in = 60; p_out = 60; end
            endcase
            in_valid  = ($urandom_range(0, 99) < p_in);
            out_ready = ($urandom_range(0, 99) < p_out);
            in_data   = DW'($urandom);
            flush     = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        repeat (3) step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmn_sync_fifo.md
CMN_SYNC_FIFO -- requirements
Module: cmn_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..512.
REQ-002 Parameter DEPTH, default 16: entry count, power of two, at least 2.
REQ-003 Parameter AFULL_TH, default DEPTH-2: almost_full asserts when count >= AFULL_TH, legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 2: almost_empty asserts when count <= AEMPTY_TH, legal range 0..DEPTH-1.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 flush  in  1  synchronous clear of contents, sampled on clk.
REQ-009 in_valid  in  1  producer offers in_data.
REQ-010 in_data  in  DATA_W  write payload.
REQ-011 in_ready  out  1  FIFO accepts a word; in_ready = not full and not rst.
REQ-012 out_valid  out  1  out_data holds the oldest stored word (first-word-fall-through).
REQ-013 out_data  out  DATA_W  head entry; don't-care while out_valid=0.
REQ-014 out_ready  in  1  consumer takes the head word.
REQ-015 count  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-016 almost_full, almost_empty  out  1 each  threshold flags derived from the registered count.
REQ-017 ovf_sticky, udf_sticky  out  1 each  sticky flags: write attempted while full, read attempted while empty.

Function
REQ-018 A push SHALL occur on a clock edge where in_valid=1 and in_ready=1; a pop SHALL occur where out_valid=1 and out_ready=1.
REQ-019 Storage SHALL be a DEPTH-entry array with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020 count SHALL update to count+1 on push only, count-1 on pop only, and remain unchanged on simultaneous push and pop.
REQ-021 full SHALL mean count==DEPTH and empty SHALL mean count==0; both derive from the registered count only, with no combinational path from out_ready to in_ready.
REQ-022 A word pushed at edge N SHALL be visible with out_valid=1 after edge N when the FIFO was empty; write-to-read latency is 1 cycle.
REQ-023 When the FIFO is full and out_ready=1, in_ready SHALL stay 0 that cycle; no push occurs and the pop proceeds.
REQ-024 When the FIFO is empty and in_valid=1, out_valid SHALL stay 0 that cycle; there is no bypass.
REQ-025 Order SHALL be strictly FIFO across any number of pointer wrap-arounds.
REQ-026 ovf_sticky SHALL set at an edge with in_valid=1 and in_ready=0 (outside reset); udf_sticky SHALL set at an edge with out_ready=1 and out_valid=0.
REQ-027 Once set, a sticky flag SHALL hold until rst or flush.
REQ-028 flush=1 SHALL set count=0, wr_ptr=0, rd_ptr=0 and clear both sticky flags at that edge.
REQ-029 flush SHALL take priority over a simultaneous push or pop; a word offered in the flush cycle is discarded.
REQ-030 in_ready SHALL stay combinationally valid during flush; array contents need not be cleared.
REQ-031 almost_full and almost_empty SHALL follow count with no additional latency.
REQ-032 Simultaneous push and pop at count==1 SHALL leave count=1 and present the new word after the edge.

Reset
REQ-033 While rst=1: count=0, pointers=0, out_valid=0, in_ready=0, almost_full=0 (unless AFULL_TH==0 is rejected), almost_empty=1, ovf_sticky=0, udf_sticky=0.
REQ-034 rst SHALL override flush, push and pop; in_ready SHALL rise in the first cycle after rst deasserts.
REQ-035 Reset mid-operation SHALL discard all stored words; the first post-reset push SHALL appear at out_data.
REQ-036 Array storage SHALL not be reset.

Verification (DATA_W=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-037 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1,2,3,4; almost_full at count 3; in_ready=0 at count 4; a fifth push with in_valid=1 sets ovf_sticky=1 and count stays 4.
REQ-038 From full, out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44, then out_valid=0; an extra out_ready cycle sets udf_sticky=1.
REQ-039 Stream 10 words 0x00..0x09 with in_valid=1 and out_ready=1 continuously -> all received in order; count oscillates 0..1; pointers wrap at least twice.
REQ-040 Full FIFO with in_valid=1 and out_ready=1 for one cycle -> pop only; count goes 4 to 3; in_ready=1 next cycle.
REQ-041 Count 2 with flush=1 and in_valid=1 in the same cycle -> count=0, out_valid=0 and sticky flags cleared next cycle; the offered word is not stored.
REQ-042 Assert rst for 1 cycle at count 3 -> in_ready=0 in that cycle, then count=0 and in_ready=1; push 0xA5 -> out_data=0xA5 with out_valid=1 one cycle later.
